// File: rtl/mul_repadd_pkg.sv
// Shared types and helpers for the repeated-addition multiplier.
// Contents: controller state encoding, magnitude helper for operand capture.
package mul_repadd_pkg;

    // Widest operand the magnitude helper accepts.
    localparam int unsigned MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Magnitude of a value already sign-extended to MAX_W bits.
    // With signed_mode clear the value is returned untouched.
    function automatic logic [MAX_W-1:0] abs_mag(input logic [MAX_W-1:0] value,
                                                 input logic             signed_mode);
        if (signed_mode && value[MAX_W-1]) begin
            return -value;
        end
        return value;
    endfunction

endpackage

// File: rtl/mul_repadd_dp.sv
// Datapath for mul_repadd_unit: operand magnitudes, addend/counter/accumulator
// registers, the accumulate adder, counter zero detect and result negation.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   load             capture operands (larger magnitude -> addend, smaller -> counter)
//   dec              accumulate addend once and decrement the counter
//   clr              clear the accumulator
//   wr_result        write the signed-corrected accumulator into product
//   a_in, b_in       operands (WIDTH bits)
//   cnt_zero         counter is zero
//   product          last result (2*WIDTH bits)
module mul_repadd_dp
    import mul_repadd_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned SIGNED = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               dec,
    input  logic               clr,
    input  logic               wr_result,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic               cnt_zero,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [MAX_W-1:0] ext_a;
    logic [MAX_W-1:0] ext_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             sign_a;
    logic             sign_b;
    logic [PW-1:0]    result_c;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] cnt;
    logic [PW-1:0]    acc;
    logic             neg;

    // Operand magnitudes; -2^(WIDTH-1) fits as a WIDTH-bit unsigned value.
    always_comb begin
        if (SIGNED != 0) begin
            ext_a  = MAX_W'($signed(a_in));
            ext_b  = MAX_W'($signed(b_in));
            sign_a = a_in[WIDTH-1];
            sign_b = b_in[WIDTH-1];
        end else begin
            ext_a  = MAX_W'(a_in);
            ext_b  = MAX_W'(b_in);
            sign_a = 1'b0;
            sign_b = 1'b0;
        end
        mag_a = WIDTH'(abs_mag(ext_a, SIGNED != 0));
        mag_b = WIDTH'(abs_mag(ext_b, SIGNED != 0));
    end

    assign cnt_zero = (cnt == '0);

    // Zero is never negated so a signed zero result stays all-zeros.
    always_comb begin
        result_c = acc;
        if (neg && (acc != '0)) begin
            result_c = -acc;
        end
    end

    // Operand, loop and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            addend  <= '0;
            cnt     <= '0;
            acc     <= '0;
            neg     <= 1'b0;
            product <= '0;
        end else begin
            if (load) begin
                // Count down the smaller magnitude to bound latency; ties keep A as addend.
                if (mag_a >= mag_b) begin
                    addend <= mag_a;
                    cnt    <= mag_b;
                end else begin
                    addend <= mag_b;
                    cnt    <= mag_a;
                end
                neg <= sign_a ^ sign_b;
            end else if (dec) begin
                cnt <= cnt - WIDTH'(1);
            end

            if (clr) begin
                acc <= '0;
            end else if (dec) begin
                acc <= acc + PW'(addend);
            end

            if (wr_result) begin
                product <= result_c;
            end
        end
    end

endmodule

// File: rtl/mul_repadd_unit.sv
// Multiply-by-repeated-addition unit: controller FSM plus datapath instance.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start            request, sampled only while ready
//   a_in, b_in       operands (WIDTH bits), sampled with start
//   ready            high in IDLE
//   busy             high in RUN and DONE
//   done             one-cycle pulse, product valid from this cycle
//   product          last result (2*WIDTH bits), held until the next done
module mul_repadd_unit
    import mul_repadd_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned SIGNED = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    state_t state;
    state_t state_d;
    logic   ready_d;
    logic   busy_d;
    logic   done_d;
    logic   load;
    logic   dec;
    logic   clr;
    logic   wr_result;
    logic   cnt_zero;

    // State and status-output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            ready <= ready_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    // Next-state, datapath controls, and next values of the status outputs.
    always_comb begin
        state_d   = state;
        load      = 1'b0;
        dec       = 1'b0;
        clr       = 1'b0;
        wr_result = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    clr     = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_zero) begin
                    wr_result = 1'b1;
                    state_d   = DONE;
                end else begin
                    dec = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    mul_repadd_dp #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_dp (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .dec       (dec),
        .clr       (clr),
        .wr_result (wr_result),
        .a_in      (a_in),
        .b_in      (b_in),
        .cnt_zero  (cnt_zero),
        .product   (product)
    );

endmodule

// File: tb/tb_mul_repadd_unit.sv
// Scoreboard bench for mul_repadd_unit: three instances (16-bit unsigned,
// 8-bit signed, 8-bit unsigned) share clock and reset. Stimulus pushes the
// expected product and done cycle; a negedge monitor pops on every done.
module tb_mul_repadd_unit;

    typedef struct {
        logic [31:0] p;
        int          c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst_q;
    logic        st  [3];
    logic [15:0] ai  [3];
    logic [15:0] bi  [3];
    logic        rdy [3];
    logic        bsy [3];
    logic        dn  [3];
    logic [31:0] p16;
    logic [15:0] ps8;
    logic [15:0] pu8;
    logic [31:0] last [3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    mul_repadd_unit #(.WIDTH(16), .SIGNED(0)) u_u16 (
        .clk(clk), .rst(rst), .start(st[0]), .a_in(ai[0]), .b_in(bi[0]),
        .ready(rdy[0]), .busy(bsy[0]), .done(dn[0]), .product(p16));

    mul_repadd_unit #(.WIDTH(8), .SIGNED(1)) u_s8 (
        .clk(clk), .rst(rst), .start(st[1]), .a_in(ai[1][7:0]), .b_in(bi[1][7:0]),
        .ready(rdy[1]), .busy(bsy[1]), .done(dn[1]), .product(ps8));

    mul_repadd_unit #(.WIDTH(8), .SIGNED(0)) u_u8 (
        .clk(clk), .rst(rst), .start(st[2]), .a_in(ai[2][7:0]), .b_in(bi[2][7:0]),
        .ready(rdy[2]), .busy(bsy[2]), .done(dn[2]), .product(pu8));

    function automatic logic [31:0] prod_of(input int i);
        case (i)
            0:       return p16;
            1:       return {16'h0, ps8};
            default: return {16'h0, pu8};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int i, input logic [31:0] p, input int c);
        exp_t e;
        e.p = p;
        e.c = c;
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop(input int i, output exp_t e, output bit ok);
        ok  = 1'b0;
        e.p = '0;
        e.c = 0;
        case (i)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    function automatic int qsize(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    // Monitor: compare product and done timing, flag stray dones,
    // product changes outside done, and busy/ready overlap.
    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        for (int i = 0; i < 3; i++) begin
            if (dn[i] === 1'b1) begin
                pop(i, e, ok);
                if (!ok) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done[%0d]: done seen with empty queue (cycle %0d)", i, cyc);
                end else begin
                    check($sformatf("product[%0d]", i), prod_of(i), e.p);
                    check($sformatf("done_cycle[%0d]", i), 32'(cyc), 32'(e.c));
                end
            end else if ((prod_of(i) !== last[i]) && (rst_q !== 1'b1)) begin
                tests++;
                fails++;
                $display("FAIL product_hold[%0d]: changed to %0h from %0h without done", i, prod_of(i), last[i]);
            end
            if ((rdy[i] === 1'b1) && (bsy[i] === 1'b1)) begin
                tests++;
                fails++;
                $display("FAIL ready_busy[%0d]: both high, required exclusive", i);
            end
            last[i] = prod_of(i);
        end
    end

    // Issue one request; n is the smaller magnitude, so done lands n+2 cycles later.
    task automatic issue(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] expp, input int n, input bit exp_done);
        int k;
        k = 0;
        @(negedge clk);
        while ((rdy[i] !== 1'b1) && (k < 600)) begin
            @(negedge clk);
            k++;
        end
        if (rdy[i] !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout[%0d]: ready %b, required 1", i, rdy[i]);
            return;
        end
        st[i] = 1'b1;
        ai[i] = a;
        bi[i] = b;
        if (exp_done) push(i, expp, cyc + n + 2);
        @(negedge clk);
        st[i] = 1'b0;
        ai[i] = 16'($urandom);
        bi[i] = 16'($urandom);
    endtask

    task automatic drain(input int i);
        int k;
        k = 0;
        while ((qsize(i) > 0) && (k < 600)) begin
            @(negedge clk);
            k++;
        end
        if (qsize(i) > 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout[%0d]: %0d results outstanding, required 0", i, qsize(i));
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            st[i] = 1'b0;
            ai[i] = '0;
            bi[i] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_ready",   32'(rdy[0]), 32'd1);
        check("rst_busy",    32'(bsy[0]), 32'd0);
        check("rst_done",    32'(dn[0]),  32'd0);
        check("rst_product", p16,         32'd0);
        check("rst_product_s8", prod_of(1), 32'd0);

        // 16-bit unsigned, back-to-back requests
        issue(0, 16'd5, 16'd3,    32'd15,   3, 1'b1);
        issue(0, 16'd0, 16'd1000, 32'd0,    0, 1'b1);
        issue(0, 16'd7, 16'd200,  32'd1400, 7, 1'b1);
        drain(0);

        // 8-bit signed
        issue(1, 16'h0080, 16'h0002, 32'h0000_FF00, 2, 1'b1);
        issue(1, 16'h00FD, 16'h00FB, 32'd15,        3, 1'b1);
        issue(1, 16'h0007, 16'h00FA, 32'h0000_FFD6, 6, 1'b1);
        issue(1, 16'h0000, 16'h00FB, 32'd0,         0, 1'b1);
        issue(1, 16'h0080, 16'h0080, 32'h0000_4000, 128, 1'b1);
        drain(1);

        // 8-bit unsigned worst case with an ignored mid-run start
        issue(2, 16'd255, 16'd255, 32'd65025, 255, 1'b1);
        repeat (10) @(negedge clk);
        check("midrun_busy",    32'(bsy[2]), 32'd1);
        check("midrun_product", prod_of(2),  32'd0);
        st[2] = 1'b1;
        ai[2] = 16'd1;
        bi[2] = 16'd1;
        @(negedge clk);
        st[2] = 1'b0;
        drain(2);
        repeat (5) @(negedge clk);
        check("after_ignored_start", prod_of(2), 32'd65025);

        // Reset aborts a 5x9 run; no done may follow
        issue(0, 16'd5, 16'd9, 32'd0, 5, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready",   32'(rdy[0]), 32'd1);
        check("abort_busy",    32'(bsy[0]), 32'd0);
        check("abort_product", p16,         32'd0);
        repeat (12) @(negedge clk);
        issue(0, 16'd6, 16'd4, 32'd24, 4, 1'b1);
        drain(0);

        check("queues_empty", 32'(qsize(0) + qsize(1) + qsize(2)), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mul_repadd_unit.md
# mul_repadd_unit

Parametrised multiply-by-repeated-addition unit with its own controller. It takes two WIDTH-bit operands on a start pulse and returns a full 2*WIDTH-bit product with a done pulse. Unsigned or signed (two's complement) operation is chosen by parameter. The loop always counts down the smaller operand magnitude, so latency is bounded by the smaller operand. It succeeds the fixed 16-bit datapath-plus-external-controller multiplier and drops into any block that needs an occasional low-area multiply.

## Interface
- WIDTH, 16, operand width; ≥ 2
- SIGNED, 0, 0 = unsigned operands; 1 = two's-complement operands and product
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only while ready = 1
- a_in  in  WIDTH  operand A; sampled with start
- b_in  in  WIDTH  operand B; sampled with start
- ready  out  1  high in IDLE only
- busy  out  1  high from the cycle after acceptance until done
- done  out  1  one-cycle pulse; product is valid from this cycle
- product  out  2*WIDTH  last result; held until the next done

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start = 1 (accept edge E0):
  - Capture magA = |a_in|, magB = |b_in| (plain value if SIGNED = 0) and neg = sign(a) XOR sign(b) (0 if unsigned).
  - Load addend register with max(magA, magB) and counter with min(magA, magB). Ties load magA as addend.
  - Clear accumulator. Go to RUN.
- RUN, counter ≠ 0: accumulator += zero-extended addend (2*WIDTH bits); counter −= 1.
- RUN, counter = 0:
  - product ← neg ? −accumulator : accumulator. A zero result is never negated.
  - Go to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE.
- Arithmetic is 2*WIDTH bits with no overflow possible.
  - Unsigned worst case: (2^WIDTH−1)^2.
  - Signed worst case: (−2^(WIDTH−1))^2 = 2^(2*WIDTH−2), which fits.
  - A magnitude of 2^(WIDTH−1) is held as a WIDTH-bit unsigned value.
- start while ready = 0 (RUN or DONE) is ignored. It is not queued.
- Operand inputs are don't-care except in the accept cycle.

## Timing
- N = min(magA, magB). Accept at edge E0; done is high in the cycle after edge E0+N+1.
  - Start-to-done latency: N+2 cycles.
  - N = 0 gives 2 cycles.
  - Max is 2^WIDTH+1 cycles unsigned, 2^(WIDTH−1)+2 signed.
- busy = 1 in RUN and DONE; ready = 1 in IDLE; busy and ready are never both high.
- Back-to-back: start may be asserted in the first IDLE cycle after done, giving a minimum of one idle cycle between requests.
- product changes only on the edge entering DONE.
- Reset values: state IDLE, ready 1, busy 0, done 0, product 0, internal registers 0.
- rst mid-operation aborts the operation. No done is produced and product returns to 0.
- rst has priority over start in the same cycle.

## Structure
- Package mul_repadd_pkg:
  - state enum (IDLE, RUN, DONE)
  - function abs_mag(value, signed_mode)
- Natural split: sub-module mul_repadd_dp holds the datapath.
  - Contents: addend/counter/accumulator registers, adder, zero comparator, result negation.
  - Controls: load, dec, clr, wr_result.
  - Status: cnt_zero.
  - The FSM stays in mul_repadd_unit.

## Test plan
- WIDTH=16, SIGNED=0, a=5, b=3 → product 15; done 5 cycles after accept.
- WIDTH=16, SIGNED=0, a=0, b=1000 → product 0; done 2 cycles after accept.
- WIDTH=16, SIGNED=0, a=7, b=200 → operands swapped internally; product 1400; done 9 cycles after accept.
- WIDTH=8, SIGNED=1, a=−128 (8'h80), b=2 → product 16'hFF00; done 4 cycles after accept.
- WIDTH=8, SIGNED=1, a=−3, b=−5 → product 15.
- WIDTH=8, SIGNED=0, a=255, b=255:
  - Product 65025, done 257 cycles after accept.
  - A second start raised mid-RUN is ignored; product unchanged until that single done.
- rst pulsed 3 cycles into a 5×9 run → ready=1, product=0, no done. A new request 6×4 then returns 24.
